// File: rtl/fb_pkg.sv
// Shared constants, fetch-state enum and default palette for the scanline prefetch stage.
package fb_pkg;

  localparam logic [15:0] FB_BASE        = 16'h4000;
  localparam int          H_ACTIVE       = 256;
  localparam int          V_ACTIVE       = 240;
  localparam int          V_TOTAL        = 262;
  localparam int          FETCH_HPOS     = 0;
  localparam int          WORDS_PER_LINE = H_ACTIVE / 8;
  localparam int          WC_W           = $clog2(WORDS_PER_LINE);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] default_palette(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'd0;
      2'd1:    return 4'd1;
      2'd2:    return 4'd4;
      default: return 4'd7;
    endcase
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Ping-pong line store: two banks of one scanline of 2bpp words, sync write, async read.
module line_buffer
  import fb_pkg::*;
(
  input  logic            clk,
  input  logic            i_we,
  input  logic            i_wr_bank,
  input  logic [WC_W-1:0] i_wr_slot,
  input  logic [15:0]     i_wr_data,
  input  logic            i_rd_bank,
  input  logic [WC_W-1:0] i_rd_slot,
  output logic [15:0]     o_rd_data
);

  logic [15:0] r_mem [2][WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_bank][i_wr_slot] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_bank][i_rd_slot];

endmodule

// File: rtl/scanline_prefetch.sv
// Fetches the next scanline into a ping-pong buffer while scanning out the current one.
// Optional runtime palette writes are enabled by defining PALETTE_WRITE_EN.
module scanline_prefetch
  import fb_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [8:0]   hpos,
  input  logic [8:0]   vpos,
  input  logic         display_on,
  output logic         mem_req,
  output logic [15:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [15:0]  mem_data,
  output logic [3:0]   rgb,
  output logic         underrun,
`ifdef PALETTE_WRITE_EN
  input  logic         pal_we,
  input  logic [1:0]   pal_idx,
  input  logic [3:0]   pal_color,
`endif
  output fetch_state_e o_dbg_state
);

  fetch_state_e    r_state, w_state_nxt;
  logic [WC_W-1:0] r_wc, w_wc_nxt;
  logic [15:0]     r_addr, w_addr_nxt;
  logic            r_bank, w_bank_nxt;
  logic            r_underrun, w_underrun_nxt;
  logic [3:0]      r_rgb;

  logic [8:0]      w_nxt;
  logic            w_trigger;
  logic [15:0]     w_line_addr;
  logic            w_ack;
  logic            w_last;
  logic [15:0]     w_rd_word;
  logic [3:0]      w_shift;
  logic [1:0]      w_pix;
  logic [3:0]      w_color;

  assign w_nxt       = (vpos == 9'(V_TOTAL - 1)) ? 9'd0 : vpos + 9'd1;
  assign w_trigger   = (hpos == 9'(FETCH_HPOS)) && (w_nxt < 9'(V_ACTIVE));
  assign w_line_addr = FB_BASE + 16'(w_nxt) * 16'(WORDS_PER_LINE);
  assign w_ack       = (r_state == FETCH) && mem_ack;
  assign w_last      = (r_wc == WC_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wc       <= '0;
      r_addr     <= '0;
      r_bank     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wc       <= w_wc_nxt;
      r_addr     <= w_addr_nxt;
      r_bank     <= w_bank_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // A trigger always wins over the running fetch; only the final-ack coincidence is not an underrun.
  always_comb begin
    w_state_nxt    = r_state;
    w_wc_nxt       = r_wc;
    w_addr_nxt     = r_addr;
    w_bank_nxt     = r_bank;
    w_underrun_nxt = r_underrun;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_state_nxt = FETCH;
          w_wc_nxt    = '0;
          w_addr_nxt  = w_line_addr;
          w_bank_nxt  = w_nxt[0];
        end
      end
      FETCH: begin
        if (mem_ack) begin
          w_wc_nxt   = r_wc + 1'b1;
          w_addr_nxt = r_addr + 16'd1;
          if (w_last) begin
            w_state_nxt = IDLE;
          end
        end
        if (w_trigger) begin
          if (!(mem_ack && w_last)) begin
            w_underrun_nxt = 1'b1;
          end
          w_state_nxt = FETCH;
          w_wc_nxt    = '0;
          w_addr_nxt  = w_line_addr;
          w_bank_nxt  = w_nxt[0];
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  line_buffer u_line_buffer (
    .clk       (clk),
    .i_we      (w_ack && !reset),
    .i_wr_bank (r_bank),
    .i_wr_slot (r_wc),
    .i_wr_data (mem_data),
    .i_rd_bank (vpos[0]),
    .i_rd_slot (hpos[7:3]),
    .o_rd_data (w_rd_word)
  );

  // Leftmost pixel sits in the MSB pair of each word.
  assign w_shift = 4'd14 - {hpos[2:0], 1'b0};
  assign w_pix   = 2'(w_rd_word >> w_shift);

`ifdef PALETTE_WRITE_EN
  logic [3:0] r_palette [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_palette[i] <= default_palette(2'(i));
      end
    end else if (pal_we) begin
      r_palette[pal_idx] <= pal_color;
    end
  end

  assign w_color = r_palette[w_pix];
`else
  assign w_color = default_palette(w_pix);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= 4'd0;
    end else begin
      r_rgb <= display_on ? w_color : 4'd0;
    end
  end

  assign mem_req     = (r_state == FETCH);
  assign mem_addr    = r_addr;
  assign rgb         = r_rgb;
  assign underrun    = r_underrun;
  assign o_dbg_state = r_state;

endmodule
